// File: rtl/watchdog_recovery_ctrl_if.sv
// Signal bundle between the host/watchdog side and watchdog_recovery_ctrl.
// The master drives requests and watchdog status; the slave drives gain, enables and status.
interface watchdog_recovery_ctrl_if #(
   parameter int GAIN_W = 8
);
   logic              rf_enable_req;
   logic              wd_warning;
   logic              wd_triggered;
   logic              fault_clear;
   logic [GAIN_W-1:0] gain_out;
   logic              tx_enable;
   logic              wd_enable;
   logic              wd_force_reset;
   logic              fault_latched;
   logic [7:0]        trip_count;
   logic [2:0]        state_out;

   modport master (
      output rf_enable_req, wd_warning, wd_triggered, fault_clear,
      input  gain_out, tx_enable, wd_enable, wd_force_reset, fault_latched,
             trip_count, state_out
   );

   modport slave (
      input  rf_enable_req, wd_warning, wd_triggered, fault_clear,
      output gain_out, tx_enable, wd_enable, wd_force_reset, fault_latched,
             trip_count, state_out
   );
endinterface

// File: rtl/watchdog_recovery_ctrl.sv
// Carrier gain ramp/derate/fade controller that recovers the AM TX path after watchdog trips
// and latches a fault once trips repeat too often.
module watchdog_recovery_ctrl #(
   parameter int GAIN_W      = 8,
   parameter int RAMP_STEP   = 16,
   parameter int HOLD_CYCLES = 1000,
   parameter int MAX_TRIPS   = 3
) (
   input  logic                    clk,
   input  logic                    rstn,
   watchdog_recovery_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAMP_UP = 3'd1,
      ST_RUN     = 3'd2,
      ST_FADE    = 3'd3,
      ST_HOLD    = 3'd4,
      ST_REARM   = 3'd5,
      ST_LOCKOUT = 3'd6
   } state_e;

   localparam int                HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [GAIN_W:0]   STEP       = (GAIN_W + 1)'(RAMP_STEP);
   localparam logic [GAIN_W:0]   GMAX_EXT   = {1'b0, {GAIN_W{1'b1}}};
   localparam logic [GAIN_W-1:0] GMAX       = {GAIN_W{1'b1}};
   localparam logic [GAIN_W-1:0] GFLOOR     = GMAX >> 1;
   localparam logic [GAIN_W-1:0] GZERO      = {GAIN_W{1'b0}};
   localparam logic [7:0]        TRIP_LIMIT = 8'(MAX_TRIPS);

   // One extra bit catches overflow so an oversized step clamps at full scale.
   function automatic logic [GAIN_W-1:0] sat_add(input logic [GAIN_W-1:0] g);
      logic [GAIN_W:0] s;
      s = {1'b0, g} + STEP;
      if (s >= GMAX_EXT) begin
         sat_add = GMAX;
      end else begin
         sat_add = s[GAIN_W-1:0];
      end
   endfunction

   function automatic logic [GAIN_W-1:0] sub_floor(input logic [GAIN_W-1:0] g,
                                                   input logic [GAIN_W-1:0] fl);
      logic [GAIN_W:0] d;
      d = {1'b0, g} - STEP;
      if (d[GAIN_W] || (d[GAIN_W-1:0] < fl)) begin
         sub_floor = fl;
      end else begin
         sub_floor = d[GAIN_W-1:0];
      end
   endfunction

   state_e            state_q, state_d;
   logic [GAIN_W-1:0] gain_q, gain_d;
   logic              tx_q, tx_d;
   logic              wd_en_q, wd_en_d;
   logic              force_q, force_d;
   logic              fault_q, fault_d;
   logic [7:0]        trip_cnt_q, trip_cnt_d;
   logic              trip_flag_q, trip_flag_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [GAIN_W-1:0] ramp_s, derate_s, fade_s;
   logic [7:0]        trip_inc_s;

   assign ramp_s     = sat_add(gain_q);
   assign derate_s   = sub_floor(gain_q, GFLOOR);
   assign fade_s     = sub_floor(gain_q, GZERO);
   assign trip_inc_s = (trip_cnt_q == 8'hFF) ? 8'hFF : (trip_cnt_q + 8'd1);

   // Next-state and next-output computation; outputs are registered from the state being entered.
   always_comb begin
      state_d     = state_q;
      gain_d      = gain_q;
      trip_cnt_d  = trip_cnt_q;
      trip_flag_d = trip_flag_q;
      hold_cnt_d  = hold_cnt_q;

      case (state_q)
         ST_IDLE: begin
            gain_d = GZERO;
            if (bus.rf_enable_req && !fault_q) begin
               state_d = ST_RAMP_UP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RAMP_UP, ST_RUN: begin
            // A trip outranks both a shutdown request and a concurrent warning.
            if (bus.wd_triggered) begin
               trip_cnt_d  = trip_inc_s;
               trip_flag_d = 1'b1;
               state_d     = ST_FADE;
            end else if (!bus.rf_enable_req) begin
               state_d = ST_FADE;
            end else if (state_q == ST_RAMP_UP) begin
               gain_d = ramp_s;
               if (ramp_s == GMAX) begin
                  state_d = ST_RUN;
               end else begin
                  state_d = ST_RAMP_UP;
               end
            end else if (bus.wd_warning) begin
               gain_d = derate_s;
            end else begin
               gain_d = ramp_s;
            end
         end
         ST_FADE: begin
            gain_d = fade_s;
            if (fade_s == GZERO) begin
               if (trip_flag_q && (trip_cnt_q >= TRIP_LIMIT)) begin
                  state_d = ST_LOCKOUT;
               end else if (trip_flag_q) begin
                  state_d    = ST_HOLD;
                  hold_cnt_d = {HOLD_W{1'b0}};
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               state_d = ST_FADE;
            end
         end
         ST_HOLD: begin
            gain_d = GZERO;
            if (hold_cnt_q == HOLD_LAST) begin
               state_d = ST_REARM;
            end else begin
               hold_cnt_d = hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
            end
         end
         ST_REARM: begin
            gain_d      = GZERO;
            trip_flag_d = 1'b0;
            state_d     = ST_IDLE;
         end
         ST_LOCKOUT: begin
            gain_d = GZERO;
            if (bus.fault_clear) begin
               trip_cnt_d = 8'd0;
               state_d    = ST_REARM;
            end else begin
               state_d = ST_LOCKOUT;
            end
         end
         default: begin
            gain_d  = GZERO;
            state_d = ST_IDLE;
         end
      endcase

      wd_en_d = (state_d == ST_RAMP_UP) || (state_d == ST_RUN);
      tx_d    = wd_en_d || ((state_d == ST_FADE) && (gain_d != GZERO));
      force_d = (state_d == ST_REARM);
      fault_d = (state_d == ST_LOCKOUT);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         gain_q      <= GZERO;
         tx_q        <= 1'b0;
         wd_en_q     <= 1'b0;
         force_q     <= 1'b0;
         fault_q     <= 1'b0;
         trip_cnt_q  <= 8'd0;
         trip_flag_q <= 1'b0;
         hold_cnt_q  <= {HOLD_W{1'b0}};
      end else begin
         state_q     <= state_d;
         gain_q      <= gain_d;
         tx_q        <= tx_d;
         wd_en_q     <= wd_en_d;
         force_q     <= force_d;
         fault_q     <= fault_d;
         trip_cnt_q  <= trip_cnt_d;
         trip_flag_q <= trip_flag_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign bus.gain_out       = gain_q;
   assign bus.tx_enable      = tx_q;
   assign bus.wd_enable      = wd_en_q;
   assign bus.wd_force_reset = force_q;
   assign bus.fault_latched  = fault_q;
   assign bus.trip_count     = trip_cnt_q;
   assign bus.state_out      = state_q;

endmodule
